// File: rtl/cpu_pkg.sv
// Shared CPU types: branch kinds, condition codes and the NZCV flag layout.
package cpu_pkg;

  typedef enum logic [2:0] {
    BR_NONE   = 3'd0,
    BR_UNCOND = 3'd1,
    BR_COND   = 3'd2,
    BR_CBZ    = 3'd3,
    BR_CBNZ   = 3'd4
  } br_kind_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000, COND_NE = 4'b0001,
    COND_HS = 4'b0010, COND_LO = 4'b0011,
    COND_MI = 4'b0100, COND_PL = 4'b0101,
    COND_VS = 4'b0110, COND_VC = 4'b0111,
    COND_HI = 4'b1000, COND_LS = 4'b1001,
    COND_GE = 4'b1010, COND_LT = 4'b1011,
    COND_GT = 4'b1100, COND_LE = 4'b1101,
    COND_AL = 4'b1110, COND_NV = 4'b1111
  } cond_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator against a stored NZCV value.
module cond_eval
  import cpu_pkg::*;
(
  input  flags_t flags,
  input  cond_t  cond,
  output logic   taken
);

  logic       base;
  logic [3:0] code;

  assign code = cond;

  // Each even code defines a predicate; the following odd code is its inverse,
  // except the 111x pair which is always taken.
  always_comb begin
    base = 1'b0;
    case (code[3:1])
      3'b000:  base = flags.z;
      3'b001:  base = flags.c;
      3'b010:  base = flags.n;
      3'b011:  base = flags.v;
      3'b100:  base = flags.c & ~flags.z;
      3'b101:  base = (flags.n == flags.v);
      3'b110:  base = ~flags.z & (flags.n == flags.v);
      default: base = 1'b1;
    endcase
    taken = (code[3:1] == 3'b111) ? 1'b1 : (base ^ code[0]);
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with the architectural NZCV register and branch resolution.
module ex_mem_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int RA_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_negative,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_carry_out,
  input  logic             ex_set_flags,
  input  logic [2:0]       ex_br_kind,
  input  logic [3:0]       ex_cond,
  input  logic [WIDTH-1:0] ex_store_data,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  output logic             mem_valid,
  output logic [WIDTH-1:0] mem_result,
  output logic [WIDTH-1:0] mem_store_data,
  output logic [RA_W-1:0]  mem_rd,
  output logic             mem_reg_write,
  output logic             mem_mem_read,
  output logic             mem_mem_write,
  output logic             mem_branch_taken,
  output logic [3:0]       flags
);

  flags_t flag_q;
  flags_t alu_flags;
  logic   eff;
  logic   cond_taken;
  logic   br_taken;

  assign eff       = ex_valid & ~flush;
  assign alu_flags = '{n: alu_negative, z: alu_zero, c: alu_carry_out, v: alu_overflow};
  assign flags     = flag_q;

  // B.cond reads the registered flags, so a flag-setter one cycle ahead is already visible.
  cond_eval u_cond_eval (
    .flags (flag_q),
    .cond  (cond_t'(ex_cond)),
    .taken (cond_taken)
  );

  always_comb begin
    br_taken = 1'b0;
    case (br_kind_t'(ex_br_kind))
      BR_UNCOND: br_taken = 1'b1;
      BR_COND:   br_taken = cond_taken;
      BR_CBZ:    br_taken = alu_zero;
      BR_CBNZ:   br_taken = ~alu_zero;
      default:   br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid        <= 1'b0;
      mem_result       <= '0;
      mem_store_data   <= '0;
      mem_rd           <= '0;
      mem_reg_write    <= 1'b0;
      mem_mem_read     <= 1'b0;
      mem_mem_write    <= 1'b0;
      mem_branch_taken <= 1'b0;
      flag_q           <= '0;
    end else if (flush) begin
      mem_valid        <= 1'b0;
      mem_result       <= '0;
      mem_store_data   <= '0;
      mem_rd           <= '0;
      mem_reg_write    <= 1'b0;
      mem_mem_read     <= 1'b0;
      mem_mem_write    <= 1'b0;
      mem_branch_taken <= 1'b0;
    end else if (!stall) begin
      mem_valid        <= eff;
      mem_result       <= alu_result;
      mem_store_data   <= ex_store_data;
      mem_rd           <= ex_rd;
      mem_reg_write    <= ex_reg_write & eff;
      mem_mem_read     <= ex_mem_read & eff;
      mem_mem_write    <= ex_mem_write & eff;
      mem_branch_taken <= br_taken & eff;
      if (eff && ex_set_flags) flag_q <= alu_flags;
    end
  end

endmodule
